// File: rtl/sprite_mem_pkg.sv
// Shared types and defaults for the sprite pixel store: geometry defaults,
// address-field widths and the clear-sequencer state type.
package sprite_mem_pkg;

  localparam int PIX_W_DEF   = 4;
  localparam int SPR_DIM_DEF = 16;
  localparam int NUM_SPR_DEF = 16;

  // Address layout is {sprite, row, col}, col in the LSBs.
  localparam int COL_W = $clog2(SPR_DIM_DEF);
  localparam int ROW_W = $clog2(SPR_DIM_DEF);
  localparam int SPR_W = $clog2(NUM_SPR_DEF);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int addr_w(input int num_spr, input int spr_dim);
    return $clog2(num_spr * spr_dim * spr_dim);
  endfunction

endpackage

// File: rtl/sprite_mem_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the
// channel after the last one granted.
module sprite_mem_rr_arbiter #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_gnt;
  logic             w_found;
  int               w_idx;

  always_comb begin
    w_gnt     = '0;
    w_found   = 1'b0;
    w_ptr_nxt = r_ptr;
    w_idx     = 0;
    for (int off = 0; off < N; off++) begin
      w_idx = int'(r_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_en && !w_found && i_req[w_idx]) begin
        w_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_ptr_nxt    = (w_idx == N - 1) ? '0 : PTR_W'(w_idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_ptr <= '0;
    else         r_ptr <= w_ptr_nxt;
  end

  assign o_gnt = w_gnt;
  assign o_ptr = r_ptr;

endmodule

// File: rtl/sprite_mem_arb.sv
// Sprite pixel store: CPU write port plus round-robin arbitrated read channels
// on one registered BRAM port. Define SPRITE_MEM_CLR_EN for the clear sequencer.
module sprite_mem_arb
  import sprite_mem_pkg::*;
#(
  parameter  int PIX_W      = PIX_W_DEF,
  parameter  int SPR_DIM    = SPR_DIM_DEF,
  parameter  int NUM_SPR    = NUM_SPR_DEF,
  parameter  int NUM_RD_CH  = 2,
  parameter  int TRANSP_IDX = 0,
  localparam int ADDR_W     = addr_w(NUM_SPR, SPR_DIM)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [PIX_W-1:0]            wr_data,
  input  logic [NUM_RD_CH-1:0]        rd_req,
  input  logic [NUM_RD_CH*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD_CH-1:0]        rd_gnt,
  output logic [NUM_RD_CH-1:0]        rd_valid,
  output logic [PIX_W-1:0]            rd_data,
  output logic                        rd_opaque,
  input  logic                        clr_start,
  output logic                        clr_busy
);

  localparam int             DEPTH  = 1 << ADDR_W;
  localparam int             PTR_W  = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;
  localparam logic [PIX_W-1:0] TRANSP = PIX_W'(TRANSP_IDX);

  logic [PIX_W-1:0]     r_mem [DEPTH];
  logic                 w_busy;
  logic                 w_mem_we;
  logic [ADDR_W-1:0]    w_mem_waddr;
  logic [PIX_W-1:0]     w_mem_wdata;
  logic [ADDR_W-1:0]    w_gnt_addr;
  logic [PTR_W-1:0]     w_rr_ptr_unused;
  logic [NUM_RD_CH-1:0] r_a_vld;
  logic [ADDR_W-1:0]    r_a_addr;
  logic [NUM_RD_CH-1:0] r_rd_valid;
  logic [PIX_W-1:0]     r_rd_data;
  logic                 r_rd_opaque;

`ifdef SPRITE_MEM_CLR_EN
  // state    | meaning
  // ST_IDLE  | normal operation, clr_start accepted
  // ST_CLEAR | sweeping TRANSP into every address, port stalled
  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= (r_state == ST_CLEAR) ? r_clr_addr + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_start)   w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (&r_clr_addr) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy      = (r_state == ST_CLEAR);
  assign w_mem_we    = w_busy | (wr_valid & wr_ready);
  assign w_mem_waddr = w_busy ? r_clr_addr : wr_addr;
  assign w_mem_wdata = w_busy ? TRANSP : wr_data;
`else
  logic w_clr_start_unused;
  assign w_clr_start_unused = clr_start;
  assign w_busy      = 1'b0;
  assign w_mem_we    = wr_valid & wr_ready;
  assign w_mem_waddr = wr_addr;
  assign w_mem_wdata = wr_data;
`endif

  assign wr_ready = ~w_busy;
  assign clr_busy = w_busy;

  sprite_mem_rr_arbiter #(.N(NUM_RD_CH)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (~w_busy),
    .i_req  (rd_req),
    .o_gnt  (rd_gnt),
    .o_ptr  (w_rr_ptr_unused)
  );

  always_comb begin
    w_gnt_addr = '0;
    for (int i = 0; i < NUM_RD_CH; i++)
      if (rd_gnt[i]) w_gnt_addr = rd_addr[i*ADDR_W +: ADDR_W];
  end

  // A same-cycle write commits before the array is read one cycle later,
  // so a colliding read naturally sees the new data.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a_vld     <= '0;
      r_a_addr    <= '0;
      r_rd_valid  <= '0;
      r_rd_data   <= '0;
      r_rd_opaque <= 1'b0;
    end else begin
      r_a_vld    <= rd_gnt;
      r_a_addr   <= w_gnt_addr;
      r_rd_valid <= r_a_vld;
      if (|r_a_vld) begin
        r_rd_data   <= r_mem[r_a_addr];
        r_rd_opaque <= (r_mem[r_a_addr] != TRANSP);
      end
    end
  end

  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_opaque = r_rd_opaque;

endmodule

// File: tb/tb_sprite_mem_arb.sv
// Self-checking bench for sprite_mem_arb; read results are checked by a
// scoreboard filled at grant time from a reference memory.
module tb_sprite_mem_arb;

  localparam int ADDR_W = 12;
  localparam int NCH    = 2;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [3:0]              wr_data;
  logic [NCH-1:0]          rd_req;
  logic [NCH*ADDR_W-1:0]   rd_addr;
  logic [NCH-1:0]          rd_gnt;
  logic [NCH-1:0]          rd_valid;
  logic [3:0]              rd_data;
  logic                    rd_opaque;
  logic                    clr_start;
  logic                    clr_busy;

  sprite_mem_arb dut (
    .clk       (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_opaque (rd_opaque),
    .clr_start (clr_start),
    .clr_busy  (clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] vld;
    logic [3:0]     data;
    logic           opq;
    int             cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_exp;
  int         m_ch;
  logic [3:0] model [1 << ADDR_W];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  int         last_gnt = 0;

  always @(posedge clk) cyc++;

  // Monitor: update reference memory, check results, enqueue new grants.
  always @(negedge clk) begin
    if (resetn) begin
      if (wr_valid && wr_ready) model[wr_addr] = wr_data;
      if (rd_valid != '0) begin
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: rd_valid=%b at cycle %0d, required no result", rd_valid, cyc);
        end else begin
          m_exp = sb.pop_front();
          if (rd_valid !== m_exp.vld || rd_data !== m_exp.data ||
              rd_opaque !== m_exp.opq || cyc !== m_exp.cyc)
            $display("FAIL sb_result: got vld=%b data=%h opq=%b cyc=%0d, required vld=%b data=%h opq=%b cyc=%0d",
                     rd_valid, rd_data, rd_opaque, cyc, m_exp.vld, m_exp.data, m_exp.opq, m_exp.cyc);
          else n_pass++;
        end
      end
      if (rd_gnt != '0) begin
        n_total++;
        if (!$onehot(rd_gnt)) $display("FAIL gnt_onehot: rd_gnt=%b, required one-hot", rd_gnt);
        else n_pass++;
        m_ch = 0;
        for (int i = NCH - 1; i >= 0; i--) if (rd_gnt[i]) m_ch = i;
        m_exp.vld  = NCH'(1) << m_ch;
        m_exp.data = model[rd_addr[m_ch*ADDR_W +: ADDR_W]];
        m_exp.opq  = (m_exp.data != 4'h0);
        m_exp.cyc  = cyc + 2;
        sb.push_back(m_exp);
      end
    end
  end

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [3:0] d);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [ADDR_W-1:0] a, output int waited);
    @(posedge clk); #1;
    rd_req[ch] = 1'b1;
    rd_addr[ch*ADDR_W +: ADDR_W] = a;
    waited = 0;
    @(negedge clk);
    while (!rd_gnt[ch] && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) begin
      n_total++;
      $display("FAIL rd_timeout: ch%0d no grant after %0d cycles, required a grant", ch, waited);
    end
    last_gnt = ch;
    @(posedge clk); #1;
    rd_req[ch] = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b, required 1", wr_ready); else n_pass++;
    n_total++; if (rd_gnt !== '0)     $display("FAIL rst_rd_gnt: got %b, required 00", rd_gnt);   else n_pass++;
    n_total++; if (rd_valid !== '0)   $display("FAIL rst_rd_valid: got %b, required 00", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 4'h0)  $display("FAIL rst_rd_data: got %h, required 0", rd_data);  else n_pass++;
    n_total++; if (rd_opaque !== 1'b0) $display("FAIL rst_rd_opaque: got %b, required 0", rd_opaque); else n_pass++;
    n_total++; if (clr_busy !== 1'b0) $display("FAIL rst_clr_busy: got %b, required 0", clr_busy); else n_pass++;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    wr(12'h123, 4'h5);
    @(posedge clk); #1;
    rd_req[0] = 1'b1;
    rd_addr[0 +: ADDR_W] = 12'h123;
    @(negedge clk);
    n_total++;
    if (rd_gnt !== 2'b01) $display("FAIL basic_gnt: got %b, required 01", rd_gnt);
    else n_pass++;
    last_gnt = 0;
    @(posedge clk); #1;
    rd_req[0] = 1'b0;
    drain();
  endtask

  task automatic test_round_robin();
    int exp_ch;
    wr(12'h010, 4'h1);
    wr(12'h020, 4'h2);
    @(posedge clk); #1;
    rd_req = 2'b11;
    rd_addr = {12'h020, 12'h010};
    exp_ch = (last_gnt + 1) % NCH;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_total++;
      if (rd_gnt !== (NCH'(1) << exp_ch))
        $display("FAIL rr_gnt%0d: got %b, required ch%0d", k, rd_gnt, exp_ch);
      else n_pass++;
      last_gnt = exp_ch;
      exp_ch = (exp_ch + 1) % NCH;
    end
    @(posedge clk); #1;
    rd_req = 2'b00;
    drain();
  endtask

  task automatic test_collision();
    wr(12'h040, 4'h3);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 12'h040; wr_data = 4'hA;
    rd_req[1] = 1'b1;
    rd_addr[ADDR_W +: ADDR_W] = 12'h040;
    @(negedge clk);
    n_total++;
    if (rd_gnt !== 2'b10) $display("FAIL coll_gnt: got %b, required 10", rd_gnt);
    else n_pass++;
    last_gnt = 1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_req[1] = 1'b0;
    drain();
  endtask

  task automatic test_opaque_top();
    int w;
    wr(12'h055, 4'h0);
    rd(0, 12'h055, w);
    n_total++; if (w !== 0) $display("FAIL transp_wait: waited %0d, required 0", w); else n_pass++;
    wr(12'hFFF, 4'hF);
    wr(12'h000, 4'h9);
    rd(1, 12'hFFF, w);
    n_total++; if (w !== 0) $display("FAIL top_wait: waited %0d, required 0", w); else n_pass++;
    rd(0, 12'h000, w);
    drain();
  endtask

`ifdef SPRITE_MEM_CLR_EN
  task automatic test_clear();
    int busy_n;
    int w;
    logic bad;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      wr_addr = ADDR_W'(a); wr_data = 4'h7;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    rd_req[0] = 1'b1;
    rd_addr[0 +: ADDR_W] = 12'h005;
    @(negedge clk);
    for (int a = 0; a < (1 << ADDR_W); a++) model[a] = 4'h0;
    busy_n = 0;
    bad = 1'b0;
    while (clr_busy === 1'b1 && busy_n < 5000) begin
      if (rd_gnt !== '0 || wr_ready !== 1'b0) bad = 1'b1;
      busy_n++;
      @(negedge clk);
    end
    n_total++; if (busy_n !== 4096) $display("FAIL clr_len: busy %0d cycles, required 4096", busy_n); else n_pass++;
    n_total++; if (bad !== 1'b0) $display("FAIL clr_stall: gnt/ready seen during clear, required stalled"); else n_pass++;
    n_total++; if (rd_gnt !== 2'b01) $display("FAIL clr_resume_gnt: got %b, required 01", rd_gnt); else n_pass++;
    last_gnt = 0;
    @(posedge clk); #1;
    rd_req[0] = 1'b0;
    for (int a = 0; a < (1 << ADDR_W); a++) rd(a % NCH, ADDR_W'(a), w);
    drain();
  endtask
`else
  task automatic test_no_clear();
    int w;
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    n_total++; if (clr_busy !== 1'b0) $display("FAIL noclr_busy: got %b, required 0", clr_busy); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL noclr_ready: got %b, required 1", wr_ready); else n_pass++;
    rd(1, 12'h123, w);
    n_total++; if (w !== 0) $display("FAIL noclr_wait: waited %0d, required 0", w); else n_pass++;
    drain();
  endtask
`endif

  task automatic test_reset_mid();
    logic seen;
    @(posedge clk); #1;
    rd_req = 2'b11;
    rd_addr = {12'h020, 12'h010};
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    rd_req = 2'b00;
    sb.delete();
    @(negedge clk);
    n_total++; if (rd_valid !== '0) $display("FAIL rstmid_valid_in: got %b, required 00", rd_valid); else n_pass++;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid !== '0) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL rstmid_valid_out: rd_valid seen after release, required none"); else n_pass++;
    @(posedge clk); #1;
    rd_req = 2'b11;
    @(negedge clk);
    n_total++; if (rd_gnt !== 2'b01) $display("FAIL rstmid_gnt: got %b, required 01", rd_gnt); else n_pass++;
    last_gnt = 0;
    @(posedge clk); #1;
    rd_req = 2'b00;
    drain();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_req    = '0;
    rd_addr   = '0;
    clr_start = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_collision();
    test_opaque_top();
`ifdef SPRITE_MEM_CLR_EN
    test_clear();
`else
    test_no_clear();
`endif
    test_reset_mid();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
